// File: rtl/systolic_pkg.sv
// Shared types for the systolic array feeder: element width, buffered vector
// layout and the feeder sequencing states.
package systolic_pkg;

   localparam int DATA_W = 16;

   typedef struct packed {
      logic [DATA_W-1:0] e1;
      logic [DATA_W-1:0] e0;
   } vec2_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      FEED,
      DRAIN,
      FIN
   } feeder_state_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// Handshake, weight and array-facing signal bundle between the feeder and its
// environment; slave is the feeder side, master is the driving side.
interface systolic_feeder_if #(
   parameter int DATA_W = systolic_pkg::DATA_W,
   parameter int CNT_W  = 4
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data0;
   logic [DATA_W-1:0] in_data1;
   logic              w_load;
   logic [DATA_W-1:0] w11;
   logic [DATA_W-1:0] w12;
   logic [DATA_W-1:0] w21;
   logic [DATA_W-1:0] w22;
   logic              go;
   logic              sys_start;
   logic              sys_load_weights;
   logic [DATA_W-1:0] sys_weight_11;
   logic [DATA_W-1:0] sys_weight_12;
   logic [DATA_W-1:0] sys_weight_21;
   logic [DATA_W-1:0] sys_weight_22;
   logic [DATA_W-1:0] sys_input_11;
   logic [DATA_W-1:0] sys_input_21;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  count;

   modport slave (
      input  in_valid, in_data0, in_data1, w_load, w11, w12, w21, w22, go,
      output in_ready, sys_start, sys_load_weights,
             sys_weight_11, sys_weight_12, sys_weight_21, sys_weight_22,
             sys_input_11, sys_input_21, busy, done, count
   );

   modport master (
      output in_valid, in_data0, in_data1, w_load, w11, w12, w21, w22, go,
      input  in_ready, sys_start, sys_load_weights,
             sys_weight_11, sys_weight_12, sys_weight_21, sys_weight_22,
             sys_input_11, sys_input_21, busy, done, count
   );

endinterface

// File: rtl/feeder_buffer.sv
// Vector store for one batch: single write port, two combinational read ports
// (current and previous step) and a synchronous clear.
module feeder_buffer
   import systolic_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             i_clr,
   input  logic             i_wr_en,
   input  logic [CNT_W-1:0] i_wr_ptr,
   input  vec2_t            i_wr_data,
   input  logic [CNT_W-1:0] i_rd_idx0,
   input  logic [CNT_W-1:0] i_rd_idx1,
   output vec2_t            o_rd_data0,
   output vec2_t            o_rd_data1
);

   vec2_t r_mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (i_clr) begin
            r_mem[i] <= '0;
         end else if (i_wr_en && (i_wr_ptr == CNT_W'(i))) begin
            r_mem[i] <= i_wr_data;
         end
      end
   end

   // Out-of-range indices (step N reads one past the batch) return zero.
   always_comb begin
      o_rd_data0 = '0;
      o_rd_data1 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_rd_idx0 == CNT_W'(i)) o_rd_data0 = r_mem[i];
         if (i_rd_idx1 == CNT_W'(i)) o_rd_data1 = r_mem[i];
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// Batch feeder for the 2x2 systolic array: buffers input vectors, latches one
// weight set, then sequences weight load, skewed feed, drain and done.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter  int DATA_W       = 16,
   parameter  int DEPTH        = 8,
   parameter  int DRAIN_CYCLES = 2,
   localparam int CNT_W        = $clog2(DEPTH + 1),
   localparam int DRN_W        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1
) (
   input logic               clk,
   input logic               rst,
   systolic_feeder_if.slave  bus
);

   feeder_state_t     r_state;
   feeder_state_t     w_nstate;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  r_k;
   logic [CNT_W-1:0]  w_nk;
   logic [DRN_W-1:0]  r_d;
   logic [DRN_W-1:0]  w_nd;

   logic [DATA_W-1:0] r_w11, r_w12, r_w21, r_w22;
   logic              r_sys_start;
   logic              r_load_w;
   logic              r_busy;
   logic              r_done;
   logic [DATA_W-1:0] r_in11, r_in21;

   logic              w_idle;
   logic              w_full;
   logic              w_wr_en;
   logic              w_start_ok;
   vec2_t             w_wr_data;
   vec2_t             w_rd0, w_rd1;
   logic [DATA_W-1:0] w_in11, w_in21;

   assign w_idle     = (r_state == IDLE);
   assign w_full     = (r_count == CNT_W'(DEPTH));
   assign w_wr_en    = bus.in_valid && bus.in_ready;
   assign w_start_ok = w_idle && bus.go && (r_count != '0);
   assign w_wr_data  = {bus.in_data1, bus.in_data0};

   // go takes priority over a simultaneous vector, so it masks in_ready.
   assign bus.in_ready = rst && w_idle && !w_full && !bus.go;

   feeder_buffer #(
      .DEPTH (DEPTH)
   ) u_buf (
      .clk        (clk),
      .i_clr      (w_nstate == FIN),
      .i_wr_en    (w_wr_en),
      .i_wr_ptr   (r_count),
      .i_wr_data  (w_wr_data),
      .i_rd_idx0  (w_nk),
      .i_rd_idx1  (w_nk - 1'b1),
      .o_rd_data0 (w_rd0),
      .o_rd_data1 (w_rd1)
   );

   always_comb begin
      w_nstate = r_state;
      w_nk     = r_k;
      w_nd     = r_d;
      unique case (r_state)
         IDLE: begin
            if (w_start_ok) w_nstate = LOAD_W;
         end
         LOAD_W: begin
            w_nstate = FEED;
            w_nk     = '0;
         end
         FEED: begin
            if (r_k == r_count) begin
               if (DRAIN_CYCLES == 0) begin
                  w_nstate = FIN;
               end else begin
                  w_nstate = DRAIN;
                  w_nd     = '0;
               end
            end else begin
               w_nk = r_k + 1'b1;
            end
         end
         DRAIN: begin
            if (r_d == DRN_W'(DRAIN_CYCLES - 1)) w_nstate = FIN;
            else                                 w_nd     = r_d + 1'b1;
         end
         FIN: begin
            w_nstate = IDLE;
         end
         default: begin
            w_nstate = IDLE;
         end
      endcase
   end

   // Outputs are computed from the next state so they line up with the state.
   always_comb begin
      w_in11 = '0;
      w_in21 = '0;
      if (w_nstate == FEED) begin
         if (w_nk < r_count) w_in11 = w_rd0.e0;
         if (w_nk != '0)     w_in21 = w_rd1.e1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_count     <= '0;
         r_k         <= '0;
         r_d         <= '0;
         r_w11       <= '0;
         r_w12       <= '0;
         r_w21       <= '0;
         r_w22       <= '0;
         r_sys_start <= 1'b0;
         r_load_w    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_in11      <= '0;
         r_in21      <= '0;
      end else begin
         r_state <= w_nstate;
         r_k     <= w_nk;
         r_d     <= w_nd;
         if (w_nstate == FIN) r_count <= '0;
         else if (w_wr_en)    r_count <= r_count + 1'b1;
         if (w_idle && bus.w_load) begin
            r_w11 <= bus.w11;
            r_w12 <= bus.w12;
            r_w21 <= bus.w21;
            r_w22 <= bus.w22;
         end
         r_sys_start <= (w_nstate == FEED) || (w_nstate == DRAIN);
         r_load_w    <= (w_nstate == LOAD_W);
         r_busy      <= (w_nstate == LOAD_W) || (w_nstate == FEED) || (w_nstate == DRAIN);
         r_done      <= (w_nstate == FIN);
         r_in11      <= w_in11;
         r_in21      <= w_in21;
      end
   end

   assign bus.sys_start        = r_sys_start;
   assign bus.sys_load_weights = r_load_w;
   assign bus.sys_weight_11    = r_w11;
   assign bus.sys_weight_12    = r_w12;
   assign bus.sys_weight_21    = r_w21;
   assign bus.sys_weight_22    = r_w22;
   assign bus.sys_input_11     = r_in11;
   assign bus.sys_input_21     = r_in21;
   assign bus.busy             = r_busy;
   assign bus.done             = r_done;
   assign bus.count            = r_count;

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage of the 2x2 systolic array. It buffers a batch of 2-element input vectors and latches one 2x2 weight set.
- On command it drives the array: a one-cycle weight-load pulse, then the input stream with a one-cycle diagonal skew, then drain cycles.
- It flags completion with a one-cycle done pulse. All array-facing outputs are registered.

Parameters:
- DATA_W, 16, width of every data and weight element.
- DEPTH, 8, maximum number of input vectors per batch (>=1).
- DRAIN_CYCLES, 2, zero-input cycles after the last skewed element, while sys_start stays high.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  feeder accepts vector this cycle.
- in_data0  in  DATA_W  vector element 0, destined for array row 1.
- in_data1  in  DATA_W  vector element 1, destined for array row 2.
- w_load  in  1  latch w11..w22 this cycle.
- w11, w12, w21, w22  in  DATA_W each  weight values.
- go  in  1  start-batch pulse.
- sys_start  out  1  array start.
- sys_load_weights  out  1  array weight-load strobe.
- sys_weight_11, sys_weight_12, sys_weight_21, sys_weight_22  out  DATA_W each  weights to the array.
- sys_input_11, sys_input_21  out  DATA_W each  skewed row inputs.
- busy  out  1  high from the cycle after go is accepted until done.
- done  out  1  one-cycle completion pulse.
- count  out  $clog2(DEPTH+1)  vectors currently buffered.

Behaviour:
- Reset (rst=0, asynchronous):
  - State is IDLE; count=0.
  - Weight registers and all outputs are 0, except in_ready, which is 1 once reset is released.
  - Reset mid-batch aborts immediately. Buffer contents are discarded and no done pulse is produced.
- FSM states: IDLE -> LOAD_W -> FEED -> DRAIN -> FIN -> IDLE.
- IDLE:
  - in_ready = !full && !go (combinational).
  - When in_valid && in_ready, the vector is written at index count and count increments.
  - When w_load=1, w11..w22 are latched; a later w_load overwrites them. w_load outside IDLE is ignored.
  - go with count>0 moves to LOAD_W. go with count==0 is ignored and the FSM stays in IDLE.
  - If go and in_valid are high together, go wins and the vector is not accepted.
- LOAD_W: 1 cycle. sys_load_weights=1, sys_weight_* = latched weights, sys_start=0, sys_input_*=0.
- FEED: N+1 cycles, where N = count at go, with step k = 0..N.
  - sys_input_11 = (k<N) ? buf[k].e0 : 0.
  - sys_input_21 = (k>=1) ? buf[k-1].e1 : 0.
  - sys_start=1.
- DRAIN: DRAIN_CYCLES cycles with sys_start=1 and sys_input_*=0. DRAIN_CYCLES=0 skips this state.
- FIN: 1 cycle. done=1, sys_start=0, busy=0, count cleared to 0. The next cycle is IDLE.
- Output timing:
  - Outputs are registered, so each state's values appear in the cycle the FSM occupies that state.
  - The cycle after the go edge is the LOAD_W cycle.
- sys_weight_* hold the latched weights in every state except reset.
- busy=1 in LOAD_W, FEED and DRAIN.
- go and in_valid outside IDLE: in_ready=0 and go is ignored.
- Full: count==DEPTH forces in_ready=0. Count never wraps.
- Go-to-done latency: 1 + (N+1) + DRAIN_CYCLES cycles, then done on the following cycle.

Decomposition:
- Shared package systolic_pkg:
  - DATA_W constant.
  - typedef vec2_t, a packed struct {e1, e0} of DATA_W each.
  - typedef feeder_state_t enum {IDLE, LOAD_W, FEED, DRAIN, FIN}.
- One sub-module, feeder_buffer:
  - DEPTH x vec2_t register array.
  - Write port (wr_en, wr_data, wr_ptr = count).
  - Two combinational read ports (idx k and idx k-1).
  - Synchronous clear input.

Test Plan:
- Reset then idle → count=0, done=0, sys_*=0, in_ready=1.
- Load w=(1,2,3,4); push vectors (5,6), (7,8), (9,10); go with DRAIN_CYCLES=2. Required response:
  - Cycle 1: sys_load_weights=1, weights=1,2,3,4.
  - Cycles 2–5: input_11 = 5, 7, 9, 0 and input_21 = 0, 6, 8, 10.
  - Cycles 6–7: zeros with sys_start=1.
  - Cycle 8: done=1, count=0.
- Push 8 vectors with DEPTH=8 → in_ready=0 on the 9th attempt, count=8. The 9th vector does not appear in FEED.
- go with count==0 → no state change, busy stays 0, no done pulse. go together with in_valid → vector not accepted, batch uses the prior count.
- Assert rst=0 during FEED step 2 → all outputs 0 immediately. After release, count=0, IDLE state, and no done pulse.
- go, in_valid and w_load asserted during DRAIN → all ignored. The batch completes with the original weights and done occurs once.
